alu_arbiter: RTL

Shares the single 8-bit ALU between two requesters, for example the execute stage and the address/branch unit. Each requester sees a valid/ready request channel and a valid/ready response channel. The arbiter grants one request at a time, drives the ALU operand and control lines from registered copies, and captures `out` and overflow into a response register. It sits between the requesters and the combinational `alu`, and it also keeps a saturating count of completed operations for debug.

---
 rtl/alu_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two valid/ready requesters.
// One operation in flight at a time: IDLE -> EXEC -> RESP -> IDLE.
// Optional feature macro: ALU_ARB_RR_EN
//   defined   -> round-robin tie break using a grant pointer (reset to 1 so req0 wins first)
//   undefined -> fixed priority, req0 always wins a tie (req1 may starve)
module alu_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_ctrl,
  input  logic             req0_flag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_ctrl,
  input  logic             req1_flag,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_ovf,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  output logic             alu_flag,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_ovf,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t           state, state_nxt;
  logic             owner;
  logic [WIDTH-1:0] op_a, op_b;
  logic [2:0]       op_ctrl;
  logic             op_flag;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_ovf_q;
  logic [CNT_W-1:0] cnt;
  logic             pick1;
  logic             accept;
  logic             rsp_fire;

`ifdef ALU_ARB_RR_EN
  // Pointer holds the last served requester; the other one wins a tie.
  logic gnt_ptr;

  assign pick1 = req1_valid && (!req0_valid || !gnt_ptr);

  // Grant pointer moves to the owner when its response is taken.
  always_ff @(posedge clk) begin
    if (!rst_n)        gnt_ptr <= 1'b1;
    else if (rsp_fire) gnt_ptr <= owner;
  end
`else
  // Fixed priority: req1 only wins when req0 is idle.
  assign pick1 = req1_valid && !req0_valid;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    accept     = 1'b0;
    rsp_fire   = 1'b0;
    case (state)
      IDLE: begin
        req1_ready = pick1;
        req0_ready = req0_valid && !pick1;
        accept     = req0_valid || req1_valid;
        if (accept) state_nxt = EXEC;
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        rsp0_valid = !owner;
        rsp1_valid = owner;
        rsp_fire   = owner ? rsp1_ready : rsp0_ready;
        if (rsp_fire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand register and owner, loaded from the winning requester on accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner   <= 1'b0;
      op_a    <= '0;
      op_b    <= '0;
      op_ctrl <= '0;
      op_flag <= 1'b0;
    end else if (accept) begin
      owner   <= pick1;
      op_a    <= pick1 ? req1_a    : req0_a;
      op_b    <= pick1 ? req1_b    : req0_b;
      op_ctrl <= pick1 ? req1_ctrl : req0_ctrl;
      op_flag <= pick1 ? req1_flag : req0_flag;
    end
  end

  // Response register captures the ALU result at the end of EXEC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_data_q <= '0;
      rsp_ovf_q  <= 1'b0;
    end else if (state == EXEC) begin
      rsp_data_q <= alu_out;
      rsp_ovf_q  <= alu_ovf;
    end
  end

  // Saturating count of completed response handshakes.
  always_ff @(posedge clk) begin
    if (!rst_n)                       cnt <= '0;
    else if (rsp_fire && (cnt != '1)) cnt <= cnt + 1'b1;
  end

  // ALU lines always reflect the operand register, so they hold outside EXEC.
  assign alu_a    = op_a;
  assign alu_b    = op_b;
  assign alu_ctrl = op_ctrl;
  assign alu_flag = op_flag;
  assign rsp_data = rsp_data_q;
  assign rsp_ovf  = rsp_ovf_q;
  assign busy     = (state != IDLE);
  assign op_count = cnt;

endmodule
